// File: rtl/cpu_pkg.sv
// Shared definitions for the serial bit demultiplexer and its word-assembly datapath.
package cpu_pkg;

  localparam int SERIAL_WORD_W = 8;

  typedef enum logic {COLLECT, HOLD} demux_state_t;

  typedef logic [SERIAL_WORD_W-1:0] serial_word_t;

endpackage

// File: rtl/bit_index_decoder.sv
// Turns a bit index into a one-hot write strobe: the write-side inverse of an N:1 select tree.
module bit_index_decoder #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     strobe_o
);

  always_comb begin
    strobe_o = '0;
    if (en_i) begin
      strobe_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_bit_demux.sv
// Serial-to-parallel demultiplexer: steers LSB-first bits into a word and presents it on valid/ready.
module serial_bit_demux
  import cpu_pkg::*;
#(
  parameter  int N     = SERIAL_WORD_W,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [IDX_W-1:0] bit_index,
  output logic             out_valid,
  output logic [N-1:0]     out_word,
  input  logic             out_ready
);

  demux_state_t     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     word_q;
  logic [N-1:0]     word_d;
  logic [N-1:0]     strobe;
  logic             valid_q;
  logic             accept;
  logic             last_bit;

  // A held word only frees the input once the sink takes it, enabling back-to-back words.
  assign in_ready = !flush && (state_q == COLLECT || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_bit = (idx_q == IDX_W'(N - 1));

  bit_index_decoder #(
    .N(N)
  ) u_decoder (
    .idx_i   (idx_q),
    .en_i    (accept && (state_q == COLLECT)),
    .strobe_o(strobe)
  );

  assign word_d = (word_q & ~strobe) | ({N{in_bit}} & strobe);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            word_q <= word_d;
            idx_q  <= idx_q + IDX_W'(1);
            if (last_bit) begin
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= COLLECT;
            // A bit accepted while the held word drains becomes bit 0 of the next word.
            if (accept) begin
              word_q <= {{(N-1){1'b0}}, in_bit};
              idx_q  <= IDX_W'(1);
            end else begin
              word_q <= '0;
              idx_q  <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bit_index = idx_q;
  assign out_valid = valid_q;
  assign out_word  = word_q;

endmodule

// File: tb/tb_serial_bit_demux.sv
// Directed self-checking bench for serial_bit_demux: stream, one-hot sweep, backpressure, flush, reset, random gaps.
module tb_serial_bit_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic [2:0] bit_index;
  logic       out_valid;
  logic [7:0] out_word;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  serial_bit_demux #(.N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .bit_index(bit_index),
    .out_valid(out_valid),
    .out_word (out_word),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      step();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_word !== 8'h00) begin errors++; $display("[TB] FAIL reset_word got %h want 00", out_word); end
    checks++; if (bit_index !== 3'd0) begin errors++; $display("[TB] FAIL reset_index got %0d want 0", bit_index); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [7:0] pat;
    pat = 8'h4D;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[i];
      checks++; if (bit_index !== 3'(i)) begin errors++; $display("[TB] FAIL stream_index got %0d want %0d", bit_index, i); end
      step();
      if (i < 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid bit %0d got %0b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid got %0b want 1", out_valid); end
    checks++; if (out_word !== 8'h4D) begin errors++; $display("[TB] FAIL stream_word got %h want 4d", out_word); end
    checks++; if (bit_index !== 3'd0) begin errors++; $display("[TB] FAIL stream_wrap got %0d want 0", bit_index); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_one_cycle got %0b want 0", out_valid); end
    checks++; if (out_word !== 8'h00) begin errors++; $display("[TB] FAIL stream_cleared got %h want 00", out_word); end
  endtask

  task automatic test_onehot();
    logic [7:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'h01 << i;
      sendWord(e);
      checks++; if (out_valid !== 1'b1 || out_word !== e) begin
        errors++; $display("[TB] FAIL onehot_%0d got valid=%0b word=%h want valid=1 word=%h", i, out_valid, out_word, e);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sendWord(8'hA5);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready cycle %0d got %0b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_word !== 8'hA5) begin
        errors++; $display("[TB] FAIL bp_hold cycle %0d got valid=%0b word=%h want valid=1 word=a5", k, out_valid, out_word);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_bit    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid got %0b want 0", out_valid); end
    checks++; if (out_word !== 8'h01) begin errors++; $display("[TB] FAIL b2b_word got %h want 01", out_word); end
    checks++; if (bit_index !== 3'd1) begin errors++; $display("[TB] FAIL b2b_index got %0d want 1", bit_index); end
    in_bit = 1'b0;
    for (int i = 1; i < 8; i++) step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_word !== 8'h01) begin
      errors++; $display("[TB] FAIL b2b_complete got valid=%0b word=%h want valid=1 word=01", out_valid, out_word);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; step();
    end
    checks++; if (bit_index !== 3'd3 || out_word !== 8'h07) begin
      errors++; $display("[TB] FAIL flush_pre got index=%0d word=%h want index=3 word=07", bit_index, out_word);
    end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (bit_index !== 3'd0 || out_word !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_clear got index=%0d word=%h valid=%0b want 0/00/0", bit_index, out_word, out_valid);
    end
    sendWord(8'h3C);
    checks++; if (out_valid !== 1'b1 || out_word !== 8'h3C) begin
      errors++; $display("[TB] FAIL flush_next got valid=%0b word=%h want valid=1 word=3c", out_valid, out_word);
    end
    step();
    out_ready = 1'b0;
    sendWord(8'hFF);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_word !== 8'h00) begin
      errors++; $display("[TB] FAIL flush_hold got valid=%0b word=%h want valid=0 word=00", out_valid, out_word);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_repeat got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; step();
    end
    in_valid = 1'b0;
    checks++; if (bit_index !== 3'd5) begin errors++; $display("[TB] FAIL areset_pre got %0d want 5", bit_index); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bit_index !== 3'd0 || out_word !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL areset_now got index=%0d word=%h valid=%0b want 0/00/0", bit_index, out_word, out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_stale got %0b want 0", out_valid); end
    sendWord(8'h96);
    checks++; if (out_valid !== 1'b1 || out_word !== 8'h96) begin
      errors++; $display("[TB] FAIL areset_word got valid=%0b word=%h want valid=1 word=96", out_valid, out_word);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0] words [16];
    int txWord = 0;
    int txBit  = 0;
    int rx     = 0;
    int cycles = 0;
    logic expReady;
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    while (rx < 16 && cycles < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (txWord < 16) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bit   = words[txWord][txBit];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
      end
      #1;
      expReady = !out_valid || out_ready;
      checks++; if (in_ready !== expReady) begin errors++; $display("[TB] FAIL rand_ready cycle %0d got %0b want %0b", cycles, in_ready, expReady); end
      if (out_valid && out_ready) begin
        checks++; if (out_word !== words[rx]) begin errors++; $display("[TB] FAIL rand_word %0d got %h want %h", rx, out_word, words[rx]); end
        rx++;
      end
      if (in_valid && in_ready) begin
        txBit++;
        if (txBit == 8) begin txBit = 0; txWord++; end
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    checks++; if (rx != 16) begin errors++; $display("[TB] FAIL rand_count got %0d want 16", rx); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_onehot();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_demux.md
Name: serial_bit_demux

Overview:
- Serial-to-parallel demultiplexer: the write-side counterpart of the 8:1 bit-select mux.
- Each accepted bit is steered into the position given by an internal 3-bit index, which stands in for the mux select S.
- After N bits the assembled word is presented on a valid/ready output.
- Sits between a serial source (debug/scan or CSR bit-stream) and the pipeline's parallel consumers.

Parameters:
- N, 8, bits per word; must be a power of two, ≥2.
- IDX_W, $clog2(N), width of the bit index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the partial or held word.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit; LSB of word first.
- in_ready  output  1  block accepts in_bit this cycle.
- bit_index  output  IDX_W  position the next accepted bit will occupy.
- out_valid  output  1  out_word holds a complete word.
- out_word  output  N  assembled word.
- out_ready  input  1  consumer accepts out_word this cycle.

Behaviour:
- One clock; reset is asynchronous and active-low; clk and reset as named above.
- Reset asserted (reset=0): immediately forces state=COLLECT, bit_index=0, out_word=0, out_valid=0.
- Reset deasserts synchronously to clk; all other logic is synchronous.
- Bit acceptance: accept = in_valid && in_ready.
- in_ready (combinational) = !flush && (state==COLLECT || out_ready).
- Outputs are registered except in_ready.
- State machine, two states:
  - COLLECT: on accept, out_word[bit_index] <= in_bit and bit_index <= bit_index+1.
  - COLLECT, bit_index==N-1 and accept: bit_index wraps to 0, out_valid<=1, state->HOLD.
  - HOLD: out_word and bit_index frozen while out_valid && !out_ready.
  - HOLD, out_ready=1 and no accept: out_valid<=0, out_word<=0, state->COLLECT.
  - HOLD, out_ready=1 and accept (back-to-back): accepted bit becomes bit 0 of the next word, i.e. out_word<=N'(in_bit), bit_index<=1, out_valid<=0, state->COLLECT. No bubble.
- Word start: out_word is all-zero whenever a new word begins. Positions not yet written read 0.
- Latency: out_valid rises the cycle after the Nth bit is accepted.
- Throughput: one bit per cycle sustained when out_ready=1.
- Gaps (in_valid=0) in COLLECT: no state change.
- flush=1 (any state): next edge bit_index=0, out_word=0, out_valid=0, state=COLLECT.
  - flush has priority over accept and out_ready; in_ready=0 while flush=1.
  - A held word being flushed with out_ready=1 in the same cycle is still considered consumed by the sink; the block does not re-present it.
- Reset mid-word: partial word discarded; no out_valid is generated for it.
- bit_index width arithmetic is modulo N, so wrap from N-1 to 0 is natural.

Decomposition:
- Shared package cpu_pkg, which holds:
  - localparam SERIAL_WORD_W=8;
  - typedef enum logic {COLLECT, HOLD} demux_state_t;
  - typedef logic [SERIAL_WORD_W-1:0] serial_word_t.
- Sub-module bit_index_decoder: IDX_W-bit index plus enable in, N-bit one-hot write strobe out. Purely combinational; the inverse of the select tree. out_word bits load from the strobe.
- Counter, FSM and handshake live in the top.

Test Plan:
- Stream bits 1,0,1,1,0,0,1,0 with out_ready=1, in_valid continuous -> out_word=8'h4D, out_valid=1 for exactly one cycle, one clock after the 8th accept; bit_index returns to 0.
- One-hot sweep, i=0..7: word with a single 1 at bit i -> out_word=8'h01<<i each time, matching the mux select order.
- Backpressure: complete word 8'hA5 with out_ready=0 for 5 cycles -> out_valid and 8'hA5 held, in_ready=0. Then out_ready=1 with in_valid=1, in_bit=1 -> next edge out_valid=0, out_word=8'h01, bit_index=1.
- Flush after 3 bits (1,1,1): bit_index=3 -> next edge bit_index=0, out_word=0. Following bits 0x3C (LSB first) -> out_word=8'h3C, with no contamination.
- Reset pulse (reset=0) mid-word at bit_index=5, asynchronous to clk -> outputs 0 immediately. After release, 8 new bits give the correct word and no stale out_valid.
- Random in_valid gaps (~50%) over 16 words with random out_ready -> every word reproduced in order; none lost or duplicated.
